// File: rtl/status_blink_sequencer.sv
// Blink-coded status LED driver: N ticked pulses then a dark gap, code taken over valid/ready.
// Optional STATUS_BLINK_REPEAT_EN: replay the last code forever, accepting a new one at gap end.
module status_blink_sequencer #(
  parameter int unsigned TICK_DIV  = 10000000,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned GAP_TICKS = 5
) (
  input  logic              clk100m_ref,
  input  logic              btn,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  output logic              code_ready_o,
  output logic              led_o,
  output logic              busy_o
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GapW  = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e            state_q, state_d;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [CODE_W-1:0] pulse_q, pulse_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              tick, gap_done, xfer;
`ifdef STATUS_BLINK_REPEAT_EN
  logic [CODE_W-1:0] code_q, code_d;
`endif

  assign tick     = (presc_q == PresW'(TICK_DIV - 1));
  assign gap_done = (state_q == StGap) && tick && (gap_q == GapW'(1));
`ifdef STATUS_BLINK_REPEAT_EN
  assign code_ready_o = (state_q == StIdle) || gap_done;
`else
  assign code_ready_o = (state_q == StIdle);
`endif
  assign xfer   = code_valid_i && code_ready_o;
  assign led_o  = led_q;
  assign busy_o = busy_q;

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    gap_d   = gap_q;
`ifdef STATUS_BLINK_REPEAT_EN
    code_d  = code_q;
`endif
    presc_d = tick ? '0 : presc_q + PresW'(1);
    if (xfer) begin
      // Restart the prescaler so every phase is aligned to the transfer edge.
      presc_d = '0;
      pulse_d = code_i;
      gap_d   = GapW'(GAP_TICKS);
      state_d = (code_i != '0) ? StOn : StGap;
`ifdef STATUS_BLINK_REPEAT_EN
      code_d  = code_i;
`endif
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StOn: if (tick) state_d = StOff;
        StOff: begin
          if (tick) begin
            pulse_d = pulse_q - CODE_W'(1);
            state_d = (pulse_q == CODE_W'(1)) ? StGap : StOn;
          end
        end
        StGap: begin
          if (tick) begin
            gap_d = gap_q - GapW'(1);
            if (gap_q == GapW'(1)) begin
`ifdef STATUS_BLINK_REPEAT_EN
              pulse_d = code_q;
              gap_d   = GapW'(GAP_TICKS);
              state_d = (code_q != '0) ? StOn : StGap;
`else
              state_d = StIdle;
`endif
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk100m_ref or negedge btn) begin
    if (!btn) begin
      state_q <= StIdle;
      presc_q <= '0;
      pulse_q <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef STATUS_BLINK_REPEAT_EN
      code_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
`ifdef STATUS_BLINK_REPEAT_EN
      code_q  <= code_d;
`endif
    end
  end

endmodule

// File: tb/tb_status_blink_sequencer.sv
// Randomized bench for status_blink_sequencer: per-cycle expectations from a timeline model
// are queued at each rising edge and compared by an independent monitor on the falling edge.
module tb_status_blink_sequencer;
  localparam int unsigned T = 4;
  localparam int unsigned G = 2;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         btn = 1'b1;
  logic [W-1:0] code = '0;
  logic         valid = 1'b0;
  logic         ready, led, busy;

  always #5 clk = ~clk;

  status_blink_sequencer #(
    .TICK_DIV (T),
    .CODE_W   (W),
    .GAP_TICKS(G)
  ) dut (
    .clk100m_ref (clk),
    .btn         (btn),
    .code_i      (code),
    .code_valid_i(valid),
    .code_ready_o(ready),
    .led_o       (led),
    .busy_o      (busy)
  );

  typedef struct packed {
    logic led;
    logic busy;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: position m_t (cycles since the transfer) within a (2N+G)*T busy window.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_code = 0;

  function automatic int total(input int n);
    return (2 * n + G) * T;
  endfunction

  function automatic bit model_ready();
    bit r;
    r = !m_active;
`ifdef STATUS_BLINK_REPEAT_EN
    r = r || (m_t == total(m_code) - 1);
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (!btn) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (valid && model_ready()) begin
      m_active = 1'b1;
      m_t = 0;
      m_code = int'(code);
    end else if (m_active) begin
      m_t++;
      if (m_t == total(m_code)) begin
`ifdef STATUS_BLINK_REPEAT_EN
        m_t = 0;
`else
        m_active = 1'b0;
`endif
      end
    end
    e.busy  = m_active;
    e.led   = m_active && ((m_t / T) < 2 * m_code) && ((m_t / T) % 2 == 0);
    e.ready = model_ready();
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_o", led, e.led);
      check("busy_o", busy, e.busy);
      check("code_ready_o", ready, e.ready);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input int c);
    code  = W'(c);
    valid = 1'b1;
    cyc(1);
    valid = 1'b0;
  endtask

  initial begin
    #1 btn = 1'b0;
    cyc(3);
    btn = 1'b1;
    cyc(20);

    send(3);
    cyc(40);
    send(0);
    cyc(12);

    // Maximum code with noise on the handshake while busy.
    send(15);
    for (int i = 0; i < 120; i++) begin
      valid = 1'($urandom_range(0, 1));
      code  = W'($urandom);
      cyc(1);
    end
    valid = 1'b0;
    cyc(140);

    // Reset mid-sequence, then a single pulse.
    send(5);
    cyc(9);
    btn = 1'b0;
    cyc(2);
    btn = 1'b1;
    send(1);
    cyc(20);

    for (int k = 0; k < 8; k++) begin
      send(int'($urandom_range(0, 15)));
      for (int i = 0; i < int'($urandom_range(10, 130)); i++) begin
        valid = ($urandom_range(0, 7) == 0);
        code  = W'($urandom);
        cyc(1);
      end
      valid = 1'b0;
      cyc(int'($urandom_range(0, 40)));
    end
    cyc(130);

    // Replay behaviour: code 2 left alone, then code 1 held valid.
    btn = 1'b0;
    cyc(1);
    btn = 1'b1;
    cyc(2);
    send(2);
    cyc(60);
    code  = W'(1);
    valid = 1'b1;
    cyc(40);
    valid = 1'b0;
    cyc(40);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_blink_sequencer.md
Name: status_blink_sequencer

Overview:
- Drives a board debug LED (dled[2] on XU5) with a blink-coded status number: N short pulses, then a long dark gap.
- Sits downstream of the 100 MHz reference clock/IBUFDS stage and the status sources (QSPI load result, optics link state); replaces the free-running toggle counter.
- Accepts a status code over a valid/ready handshake and plays it out at a prescaled tick rate.

Parameters:
- TICK_DIV, 10000000, clock cycles per blink tick (100 ms at 100 MHz); must be >= 2.
- CODE_W, 4, width of the status code; max pulse count is 2^CODE_W-1.
- GAP_TICKS, 5, dark ticks after the last pulse; must be >= 1.

Ports:
- clk100m_ref  in  1  100 MHz reference clock, the only clock.
- btn  in  1  reset, asynchronous, active-low.
- code_i  in  CODE_W  status code = number of pulses to blink.
- code_valid_i  in  1  code_i is valid.
- code_ready_o  out  1  block can accept a code (IDLE only).
- led_o  out  1  LED drive, 1 = on.
- busy_o  out  1  sequence in progress (not IDLE).

Behaviour:
- Reset (btn=0, async): state IDLE, prescaler=0, pulse counter=0, code register=0, led_o=0, busy_o=0, code_ready_o=1 (decoded from IDLE).
- Handshake: transfer on the rising edge where code_valid_i && code_ready_o. code_i is registered at the transfer; later changes on code_i are ignored until IDLE. code_valid_i outside IDLE is ignored and not queued.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1). It clears to 0 on the transfer cycle, so all timing is relative to the transfer.
- States:
  - IDLE: on transfer, go to ON if code != 0, else GAP. Pulse counter loads the code; gap counter loads GAP_TICKS.
  - ON: led_o=1. On tick go to OFF.
  - OFF: led_o=0. On tick, decrement the pulse counter. If the result is 0, go to GAP, else go to ON.
  - GAP: led_o=0. On each tick, decrement the gap counter. At 0, go to IDLE.
- led_o is registered and equals 1 exactly in ON. It rises on the cycle after the transfer edge.
- Each ON or OFF phase lasts exactly TICK_DIV cycles. The GAP phase lasts GAP_TICKS*TICK_DIV cycles.
- Total busy time = (2N + GAP_TICKS)*TICK_DIV cycles. code_ready_o returns high on the cycle after that.
- Code 0: no pulses, GAP only, led_o stays 0 throughout.
- Maximum code (2^CODE_W-1): the pulse counter must not wrap; the counter is CODE_W bits wide.
- Reset mid-sequence: immediate return to the reset values. No partial pulse completes after btn rises again.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro: STATUS_BLINK_REPEAT_EN.
- Defined:
  - At the end of GAP, if code_valid_i is high, the new code is transferred. code_ready_o is also high on that final-tick cycle of GAP.
  - Otherwise the registered code replays without passing through IDLE.
  - The LED therefore loops the last status until a new one arrives. busy_o stays 1 after the first transfer until reset.
- Undefined: GAP always returns to IDLE, led_o=0, and a new transfer is required.

Test Plan:
All scenarios use TICK_DIV=4, GAP_TICKS=2, CODE_W=4.
1. Reset, then idle 20 cycles -> led_o=0, busy_o=0, code_ready_o=1 throughout.
2. Transfer code 3 at cycle 0:
   - led_o=1 on cycles 1-4, 9-12 and 17-20; 0 elsewhere.
   - code_ready_o=0 on cycles 1-32, back to 1 at cycle 33.
3. Transfer code 0 -> led_o never 1, busy_o=1 for cycles 1-8, code_ready_o=1 at cycle 9.
4. Transfer code 15, then toggle code_i and code_valid_i during the sequence -> exactly 15 pulses, busy for 128 cycles, extra valids ignored.
5. Transfer code 5, assert btn=0 at cycle 10 for 2 cycles -> led_o=0 immediately and IDLE. After release, a new code 1 gives a single 4-cycle pulse.
6. With STATUS_BLINK_REPEAT_EN defined, transfer code 2 and keep code_valid_i low:
   - led_o pattern repeats with a 24-cycle period, busy_o stays 1.
   - Holding code_valid_i high with code 1 at the end of GAP switches the pattern to 1 pulse per 16 cycles.
